dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and returns a response after a fixed latency.
- Owns a word-addressed storage array and applies byte, half and word writes and reads within it.
- Sits opposite the core's memory-stage initiator. It is the stimulus target the pd-level top instantiates and probes.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; only 32 is supported
- DEPTH_WORDS, 1024, number of 32-bit words in the array
- BASE_ADDR, 32'h0100_0000, byte address of word 0
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous reset, active-low (asserted when 0, sampled on the clock edge)
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  access size; encodings are in the package
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response available
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  DATA_W  load data, zero-extended and right-aligned; 0 for stores and errors
- resp_err  out  1  request rejected (misaligned, out of range, or reserved size)

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - req_ready=0 while reset is low; it is 1 on the first cycle after release.
  - Array contents are not cleared.
- States:
  - IDLE: req_ready=1.
    - On req_valid&&req_ready, latch addr/we/size/wdata.
    - If LATENCY==1, go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. Decrement cnt each cycle; when cnt==0, go to RESP at the next edge.
  - RESP: resp_valid=1, req_ready=0. resp_rdata and resp_err are registered on entry and held stable until handshake.
    - On resp_valid&&resp_ready, go to IDLE.
- Latency:
  - Acceptance at edge N gives resp_valid=1 in the cycle after edge N+LATENCY-1.
  - Minimum spacing between accepted requests is LATENCY+1 cycles; there is no pipelining and only one request is outstanding.
- Commit point: on the edge that enters RESP, a load samples the array and a store writes it. A store therefore changes memory exactly once.
- Error checks, evaluated on the latched request:
  - size==HALF with addr[0]!=0 is an error.
  - size==WORD with addr[1:0]!=0 is an error.
  - size==RSVD is an error.
  - addr<BASE_ADDR or word index>=DEPTH_WORDS is an error.
  - On error: resp_err=1, resp_rdata=0, and no write occurs.
- Indexing:
  - word index = (addr-BASE_ADDR)>>2; byte lane = addr[1:0].
  - Little-endian: a byte write updates only the selected lane; a half write updates lanes {addr[1],0} and {addr[1],1}.
- Loads return the selected lane(s) shifted to bit 0 and zero-extended. Sign extension is the core's job.
- Stores return resp_rdata=0 and resp_err=0 on success.
- Handshake rules:
  - req_* inputs are ignored unless IDLE.
  - The response is held indefinitely while resp_ready==0.
  - resp_ready asserted while resp_valid==0 has no effect.
- Reset mid-operation:
  - A request in WAIT is dropped and its store is never committed.
  - A response in RESP is dropped.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_RSVD=2'b11;
  - the state enum {IDLE, WAIT, RESP};
  - a lane-mask function (size, addr[1:0]) -> 4-bit byte enable.
- One sub-module, dmem_array: a synchronous single-port word array with a 4-bit byte-enable write and a registered read. It has no reset on its contents.

Test Plan:
1. Hold reset=0 for 3 cycles -> resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0. In the first cycle after reset=1, req_ready=1.
2. Store WORD 0xDEADBEEF at 0x01000004, then load WORD at 0x01000004 with LATENCY=2 -> each resp_valid rises 2 cycles after acceptance. Load resp_rdata=0xDEADBEEF, resp_err=0.
3. Store BYTE 0xAA at 0x01000006, then load WORD at 0x01000004 -> 0xDEAABEEF. Load HALF at 0x01000006 -> 0x0000DEAA.
4. Load HALF at 0x01000005, WORD at 0x01000002, and WORD at 0x00FFFFFC -> each gives resp_err=1, resp_rdata=0. A store WORD 0x12345678 at 0x01000006 gives resp_err=1, and a subsequent word load from 0x01000004 still returns 0xDEAABEEF.
5. Hold resp_ready=0 for 5 cycles during RESP while driving a new req_valid -> resp_valid, resp_rdata and resp_err are stable and req_ready=0. After resp_ready=1, the state returns to IDLE and the new request is accepted the following cycle.
6. Store WORD 0x0 at 0x01000004 and pulse reset=0 while in WAIT -> no response is produced. A subsequent load from 0x01000004 returns 0xDEAABEEF, showing the store was never committed.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings for the data-memory responder: access sizes,
//               FSM states and the byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte enables for an access of the given size starting at byte lane 'lane'.
  // Alignment is checked elsewhere; a reserved size enables nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lane;
      SIZE_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port word array with per-byte write enables and a
//               registered read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Load/store responder. Accepts one request at a time, waits a
//               fixed latency, commits the access on entry to RESP and holds
//               the response until the initiator takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0100_0000,
  parameter int                LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 2);
  localparam bit         SINGLE_CY = (LATENCY == 1);

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;

  logic                accept;
  logic                commit;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_we;
  logic [1:0]          cur_size;
  logic [DATA_W-1:0]   cur_wdata;
  logic [ADDR_W-1:0]   word_off;
  logic                err_now;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   arr_rdata;
  logic [DATA_W-1:0]   shifted;

  assign accept = req_valid && req_ready;

  // With single-cycle latency the commit edge is the acceptance edge, so the
  // access is evaluated on the live request; otherwise on the latched copy.
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_size  = (state == IDLE) ? req_size  : size_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  // Reset gates the commit so a dropped request never touches memory.
  assign commit = reset && (((state == WAIT) && (cnt == 4'd0)) ||
                            ((state == IDLE) && accept && SINGLE_CY));

  assign word_off = (cur_addr - BASE_ADDR) >> 2;

  // Alignment, reserved-size and range checks on the request being committed.
  always_comb begin
    err_now = 1'b0;
    if (cur_size == SIZE_RSVD) err_now = 1'b1;
    if ((cur_size == SIZE_HALF) && cur_addr[0]) err_now = 1'b1;
    if ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00)) err_now = 1'b1;
    if (cur_addr < BASE_ADDR) err_now = 1'b1;
    if (word_off >= ADDR_W'(DEPTH_WORDS)) err_now = 1'b1;
  end

  // Replicate right-aligned store data across all lanes; the mask picks lanes.
  always_comb begin
    lane_wdata = cur_wdata;
    case (cur_size)
      SIZE_BYTE: lane_wdata = {4{cur_wdata[7:0]}};
      SIZE_HALF: lane_wdata = {2{cur_wdata[15:0]}};
      default:   lane_wdata = cur_wdata;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .DATA_W      (DATA_W)
  ) u_array (
    .clock (clock),
    .wr_en (commit && cur_we && !err_now),
    .rd_en (commit && !cur_we && !err_now),
    .be    (lane_mask(cur_size, cur_addr[1:0])),
    .idx   (word_off[IDX_W-1:0]),
    .wdata (lane_wdata),
    .rdata (arr_rdata)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SINGLE_CY ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, latency counter and error flag captured at commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit)                            err_q <= err_now;
      else if ((state == RESP) && resp_ready) err_q <= 1'b0;
    end
  end

  assign shifted = arr_rdata >> {addr_q[1:0], 3'b000};

  // Handshake outputs and zero-extended load data from the registered read.
  always_comb begin
    req_ready  = reset && (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = err_q;
    resp_rdata = '0;
    if ((state == RESP) && !we_q && !err_q) begin
      case (size_q)
        SIZE_BYTE: resp_rdata = {{(DATA_W-8){1'b0}},  shifted[7:0]};
        SIZE_HALF: resp_rdata = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        default:   resp_rdata = shifted;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder: directed scenarios
//               plus randomized traffic against a byte-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  // Byte-addressed reference memory; only bytes ever written are known.
  logic [7:0] mb [int unsigned];

  dmem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int nbytes(input logic [1:0] s);
    return (s == SIZE_BYTE) ? 1 : (s == SIZE_HALF) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
    if (s == SIZE_RSVD) return 1'b1;
    if ((s == SIZE_HALF) && (a % 2 != 0)) return 1'b1;
    if ((s == SIZE_WORD) && (a % 4 != 0)) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((a - BASE) / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) mb[a + i] = d[8*i +: 8];
  endtask

  task automatic model_load(input logic [31:0] a, input logic [1:0] s,
                            output bit known, output logic [31:0] d);
    known = 1'b1;
    d = '0;
    for (int i = 0; i < nbytes(s); i++) begin
      if (mb.exists(a + i)) d[8*i +: 8] = mb[a + i];
      else known = 1'b0;
    end
  endtask

  // One complete transaction. Entered and left at 1 time unit after a rising
  // edge. lat = edges after the acceptance edge until resp_valid (99 = never).
  task automatic xact(input logic [31:0] a, input logic we, input logic [1:0] s,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic e, output int lat,
                      output logic rdy);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = s; req_wdata = wd;
    rdy = req_ready;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    if (resp_valid !== 1'b1) lat = 99;
    rd = resp_rdata;
    e  = resp_err;
    if (resp_valid === 1'b1) begin
      repeat (hold) begin @(posedge clock); #1; end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_we = 1'b0; req_size = SIZE_BYTE; req_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_low: got %b expected 0", req_ready); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_release: got %b expected 1", req_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic e, rdy; int lat;
    xact(32'h0100_0004, 1'b1, SIZE_WORD, 32'hDEAD_BEEF, 0, rd, e, lat, rdy);
    model_store(32'h0100_0004, SIZE_WORD, 32'hDEAD_BEEF);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL word_store_ready: got %b expected 1", rdy); end
    checks++; if (lat != LAT - 1) begin errors++; $display("FAIL word_store_latency: got %0d expected %0d", lat, LAT - 1); end
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store_resp: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
    xact(32'h0100_0004, 1'b0, SIZE_WORD, 32'h0, 0, rd, e, lat, rdy);
    checks++; if (lat != LAT - 1) begin errors++; $display("FAIL word_load_latency: got %0d expected %0d", lat, LAT - 1); end
    checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL word_load_data: got err=%b rdata=%h expected err=0 rdata=deadbeef", e, rd); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic e, rdy; int lat;
    xact(32'h0100_0006, 1'b1, SIZE_BYTE, 32'h0000_00AA, 0, rd, e, lat, rdy);
    model_store(32'h0100_0006, SIZE_BYTE, 32'h0000_00AA);
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL byte_store_resp: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
    xact(32'h0100_0004, 1'b0, SIZE_WORD, 32'h0, 0, rd, e, lat, rdy);
    checks++; if (rd !== 32'hDEAA_BEEF || e !== 1'b0) begin errors++; $display("FAIL byte_merge_word: got err=%b rdata=%h expected err=0 rdata=deaabeef", e, rd); end
    xact(32'h0100_0006, 1'b0, SIZE_HALF, 32'h0, 0, rd, e, lat, rdy);
    checks++; if (rd !== 32'h0000_DEAA || e !== 1'b0) begin errors++; $display("FAIL half_load_upper: got err=%b rdata=%h expected err=0 rdata=0000deaa", e, rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e, rdy; int lat;
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    logic        wes   [4];
    addrs[0] = 32'h0100_0005; sizes[0] = SIZE_HALF; wes[0] = 1'b0;
    addrs[1] = 32'h0100_0002; sizes[1] = SIZE_WORD; wes[1] = 1'b0;
    addrs[2] = 32'h00FF_FFFC; sizes[2] = SIZE_WORD; wes[2] = 1'b0;
    addrs[3] = 32'h0100_0006; sizes[3] = SIZE_WORD; wes[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xact(addrs[i], wes[i], sizes[i], 32'h1234_5678, 0, rd, e, lat, rdy);
      checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL error_case_%0d: got err=%b rdata=%h expected err=1 rdata=0", i, e, rd); end
    end
    xact(32'h0100_0004, 1'b0, SIZE_WORD, 32'h0, 0, rd, e, lat, rdy);
    checks++; if (rd !== 32'hDEAA_BEEF || e !== 1'b0) begin errors++; $display("FAIL error_no_write: got err=%b rdata=%h expected err=0 rdata=deaabeef", e, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0; logic e0; bit stable; int n;
    req_valid = 1'b1; req_addr = 32'h0100_0004; req_we = 1'b0; req_size = SIZE_WORD;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_first_resp: got resp_valid=%b expected 1", resp_valid); end
    r0 = resp_rdata; e0 = resp_err;
    req_valid = 1'b1; req_addr = 32'h0100_0006; req_we = 1'b0; req_size = SIZE_HALF;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== r0 || resp_err !== e0 || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold_stable: got unstable response or req_ready=%b expected stable", req_ready); end
    checks++; if (r0 !== 32'hDEAA_BEEF || e0 !== 1'b0) begin errors++; $display("FAIL bp_held_data: got err=%b rdata=%h expected err=0 rdata=deaabeef", e0, r0); end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready); end
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accepted: got req_ready=%b expected 0", req_ready); end
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    checks++; if (resp_rdata !== 32'h0000_DEAA || resp_valid !== 1'b1) begin errors++; $display("FAIL bp_next_data: got valid=%b rdata=%h expected 1 0000deaa", resp_valid, resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e, rdy; int lat; bit seen;
    req_valid = 1'b1; req_addr = 32'h0100_0004; req_we = 1'b1; req_size = SIZE_WORD; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midwait_no_resp: got a response expected none"); end
    xact(32'h0100_0004, 1'b0, SIZE_WORD, 32'h0, 0, rd, e, lat, rdy);
    checks++; if (rd !== 32'hDEAA_BEEF || e !== 1'b0) begin errors++; $display("FAIL midwait_no_commit: got err=%b rdata=%h expected err=0 rdata=deaabeef", e, rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_d; logic e, rdy, we; logic [1:0] s; int lat, sel;
    bit exp_e, known;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      xact(BASE + 32'(4 * w), 1'b1, SIZE_WORD, wd, 0, rd, e, lat, rdy);
      model_store(BASE + 32'(4 * w), SIZE_WORD, wd);
    end
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = BASE + 32'(4 * DEPTH) - 32'd8 + 32'($urandom_range(0, 15));
      else if (sel == 1) a = BASE - 32'd8 + 32'($urandom_range(0, 7));
      else               a = BASE + 32'($urandom_range(0, 31));
      s  = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_e = model_err(a, s);
      xact(a, we, s, wd, $urandom_range(0, 3), rd, e, lat, rdy);
      checks++; if (lat != LAT - 1 || rdy !== 1'b1) begin errors++; $display("FAIL rand_latency_%0d: got lat=%0d ready=%b expected %0d 1", k, lat, rdy, LAT - 1); end
      checks++; if (e !== exp_e) begin errors++; $display("FAIL rand_err_%0d: addr=%h size=%0d got %b expected %b", k, a, s, e, exp_e); end
      if (we || exp_e) begin
        exp_d = 32'h0;
        known = 1'b1;
        if (we && !exp_e) model_store(a, s, wd);
      end else begin
        model_load(a, s, known, exp_d);
      end
      if (known) begin
        checks++; if (rd !== exp_d) begin errors++; $display("FAIL rand_data_%0d: addr=%h size=%0d we=%b got %h expected %h", k, a, s, we, rd, exp_d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
